// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared types, mode encodings and saturating-add helper
package multi_counter_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam logic MODE_DIFF = 1'b0;
    localparam logic MODE_MUL = 1'b1;
    localparam logic MODE_CHANGE = 1'b0;
    localparam logic MODE_CUMUL = 1'b1;
    localparam int MAX_RES = 64;
    typedef logic signed [MAX_RES-1:0] wide_t;
    function automatic wide_t sat_hi(input int res);
        return (wide_t'(1) <<< (res - 1)) - wide_t'(1);
    endfunction
    function automatic wide_t sat_lo(input int res);
        return -sat_hi(res);
    endfunction
    // Returns {clamped, sum}; operands must already lie within the res-bit range.
    function automatic logic [MAX_RES:0] sat_add(input wide_t acc, input wide_t term, input int res);
        wide_t sum;
        sum = acc + term;
        if (sum > sat_hi(res)) return {1'b1, sat_hi(res)};
        if (sum < sat_lo(res)) return {1'b1, sat_lo(res)};
        return {1'b0, sum};
    endfunction
endpackage

// File: rtl/multi_counter_lane.sv
// multi_counter_lane: one channel's term compute, change detect and saturating accumulator
module multi_counter_lane
    import multi_counter_pkg::*;
#(
    parameter int WORD_WIDTH = 2,
    parameter int RESOLUTION = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         sample,
    input  logic                         win_end,
    input  logic                         multiply,
    input  logic                         cumulative,
    input  logic [WORD_WIDTH-1:0]        p,
    input  logic [WORD_WIDTH-1:0]        n,
    output logic signed [RESOLUTION-1:0] sum,
    output logic                         sat
);
    localparam int TW = 2 * WORD_WIDTH + 2;
    logic signed [RESOLUTION-1:0] acc;
    logic signed [RESOLUTION-1:0] term_x;
    logic signed [TW-1:0] pw, nw, term;
    logic [2*WORD_WIDTH-1:0] last;
    logic [MAX_RES:0] r;
    logic sat_q;
    always_comb begin
        pw = TW'($signed({1'b0, p}));
        nw = TW'($signed({1'b0, n}));
        term = (multiply == MODE_MUL) ? pw * nw : pw - nw;
        term_x = (cumulative == MODE_CHANGE && {p, n} == last) ? '0 : RESOLUTION'(term);
        r = sat_add(wide_t'(acc), wide_t'(term_x), RESOLUTION);
        sum = r[RESOLUTION-1:0];
        sat = sat_q | r[MAX_RES];
    end
    // A window end restarts the lane so the next sample opens the new window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            sat_q <= 1'b0;
            last <= '0;
        end else if (clear) begin
            acc <= '0;
            sat_q <= 1'b0;
            last <= '0;
        end else if (sample) begin
            last <= {p, n};
            acc <= win_end ? '0 : sum;
            sat_q <= win_end ? 1'b0 : sat;
        end
    end
endmodule

// File: rtl/multi_counter.sv
// multi_counter: NUM_CHANNELS accumulators sharing one window controller,
// with snapshots handed out over a valid/ready register.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WORD_WIDTH   = 2,
    parameter int RESOLUTION   = 32,
    parameter int WINDOW_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sample_en,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_p,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_n,
    input  logic                               multiply,
    input  logic                               cumulative,
    input  logic [WINDOW_WIDTH-1:0]            window_len,
    input  logic                               start,
    input  logic                               stop,
    output logic                               busy,
    output logic [NUM_CHANNELS*RESOLUTION-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]            out_sat,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overrun
);
    state_t state;
    logic [WINDOW_WIDTH-1:0] count, len_q, cnt_inc;
    logic mult_q, cum_q, go, halt, sample, win_end, clear;
    logic [NUM_CHANNELS*RESOLUTION-1:0] sums;
    logic [NUM_CHANNELS-1:0] sats;
    always_comb begin
        go = state == IDLE && start && window_len != '0;
        halt = state == RUN && stop;
        sample = state == RUN && sample_en && !stop;
        cnt_inc = count + 1'b1;
        win_end = sample && cnt_inc == len_q;
        clear = go || halt;
    end
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        multi_counter_lane #(
            .WORD_WIDTH(WORD_WIDTH),
            .RESOLUTION(RESOLUTION)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .sample    (sample),
            .win_end   (win_end),
            .multiply  (mult_q),
            .cumulative(cum_q),
            .p         (in_p[c*WORD_WIDTH +: WORD_WIDTH]),
            .n         (in_n[c*WORD_WIDTH +: WORD_WIDTH]),
            .sum       (sums[c*RESOLUTION +: RESOLUTION]),
            .sat       (sats[c])
        );
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            count <= '0;
            len_q <= '0;
            mult_q <= MODE_DIFF;
            cum_q <= MODE_CHANGE;
        end else if (go) begin
            state <= RUN;
            busy <= 1'b1;
            count <= '0;
            len_q <= window_len;
            mult_q <= multiply;
            cum_q <= cumulative;
        end else if (halt) begin
            state <= IDLE;
            busy <= 1'b0;
            count <= '0;
        end else if (sample) begin
            count <= win_end ? '0 : cnt_inc;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_sat <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= win_end && out_valid && !out_ready;
            if (win_end) begin
                out_data <= sums;
                out_sat <= sats;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed checks of windowing, modes, saturation, handshake and reset
module tb_multi_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sample_en = 1'b0;
    logic [7:0] in_p = '0, in_n = '0;
    logic multiply = 1'b0, cumulative = 1'b0;
    logic [15:0] window_len = '0;
    logic start = 1'b0, stop = 1'b0, out_ready = 1'b0;
    logic busy, out_valid, overrun, busy8, out_valid8, overrun8;
    logic [127:0] out_data;
    logic [31:0] out_data8;
    logic [3:0] out_sat, out_sat8;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_counter dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .in_p(in_p), .in_n(in_n),
        .multiply(multiply), .cumulative(cumulative), .window_len(window_len),
        .start(start), .stop(stop), .busy(busy), .out_data(out_data), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
    );

    multi_counter #(.RESOLUTION(8)) dut8 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .in_p(in_p), .in_n(in_n),
        .multiply(multiply), .cumulative(cumulative), .window_len(window_len),
        .start(start), .stop(stop), .busy(busy8), .out_data(out_data8), .out_sat(out_sat8),
        .out_valid(out_valid8), .out_ready(out_ready), .overrun(overrun8)
    );

    task automatic tick(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_run(input logic m, input logic cu, input logic [15:0] len);
        multiply = m;
        cumulative = cu;
        window_len = len;
        sample_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_run();
        sample_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", out_sat, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick();

        // diff, cumulative, window 4, ch0 p=3 n=1
        in_p = 8'h03;
        in_n = 8'h01;
        begin_run(1'b0, 1'b1, 16'd4);
        check("diff_busy", busy, 1);
        sample_en = 1'b1;
        tick(3);
        check("diff_valid_early", out_valid, 0);
        tick();
        check("diff_valid", out_valid, 1);
        check("diff_data", out_data, 128'd8);
        check("diff_sat", out_sat, 0);
        out_ready = 1'b1;
        tick();
        check("diff_drop", out_valid, 0);
        tick(3);
        check("diff_valid2", out_valid, 1);
        check("diff_data2", out_data, 128'd8);
        end_run();
        check("diff_stopped", busy, 0);

        // multiply, change-only, window 3, ch1 (2,3),(2,3),(1,1)
        begin_run(1'b1, 1'b0, 16'd3);
        sample_en = 1'b1;
        in_p = 8'h08;
        in_n = 8'h0C;
        tick(2);
        in_p = 8'h04;
        in_n = 8'h04;
        tick();
        check("mul_valid", out_valid, 1);
        check("mul_data", out_data, {32'd0, 32'd0, 32'd7, 32'd0});
        end_run();

        // p=n=3 multiply, window 20: 8-bit instance clamps at 127
        in_p = 8'h03;
        in_n = 8'h03;
        begin_run(1'b1, 1'b1, 16'd20);
        sample_en = 1'b1;
        tick(20);
        check("sat8_valid", out_valid8, 1);
        check("sat8_data", out_data8, 32'h7F);
        check("sat8_flag", out_sat8, 4'b0001);
        check("sat32_data", out_data, 128'd180);
        check("sat32_flag", out_sat, 0);
        in_p = 8'h01;
        in_n = 8'h01;
        tick(20);
        check("sat8_data2", out_data8, 32'd20);
        check("sat8_flag2", out_sat8, 0);
        end_run();

        // overrun: two window ends with out_ready low
        out_ready = 1'b0;
        tick();
        in_p = 8'h03;
        in_n = 8'h01;
        begin_run(1'b0, 1'b1, 16'd2);
        sample_en = 1'b1;
        tick(2);
        check("ovr_first_data", out_data, 128'd4);
        check("ovr_first_pulse", overrun, 0);
        in_p = 8'h01;
        in_n = 8'h00;
        tick(2);
        check("ovr_pulse", overrun, 1);
        check("ovr_data", out_data, 128'd2);
        sample_en = 1'b0;
        tick();
        check("ovr_once", overrun, 0);
        check("ovr_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("ovr_accept_drop", out_valid, 0);
        end_run();

        // stop after 2 of 4 samples, then clean restart
        in_p = 8'h03;
        in_n = 8'h01;
        begin_run(1'b0, 1'b1, 16'd4);
        sample_en = 1'b1;
        tick(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        tick(4);
        check("stop_no_valid", out_valid, 0);
        begin_run(1'b0, 1'b1, 16'd4);
        sample_en = 1'b1;
        tick(3);
        check("restart_early", out_valid, 0);
        tick();
        check("restart_data", out_data, 128'd8);
        end_run();

        // async reset mid-run with out_valid high
        out_ready = 1'b0;
        begin_run(1'b0, 1'b1, 16'd1);
        sample_en = 1'b1;
        tick();
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_sat", out_sat, 0);
        check("arst_overrun", overrun, 0);
        tick();
        reset = 1'b1;
        begin_run(1'b0, 1'b1, 16'd0);
        check("zero_len_busy", busy, 0);
        sample_en = 1'b1;
        tick(3);
        check("zero_len_valid", out_valid, 0);
        sample_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
